// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and parity helper for the UART receive path.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Parity bit a well-formed frame carries for this data byte.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every CLK_DIV clocks, restartable so
// a receiver can phase-align sampling to a detected start edge.
module uart_baud_tick #(
  parameter int CLK_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  logic [9:0] div_cnt;

  assign tick = (div_cnt == 10'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 10'd1;
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver, 8 data bits, LSB first, one stop bit.
// Define UART_RX_PARITY_EN to add a parity bit (even, or odd when PARITY_ODD=1).
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 27,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_frame_err,
  output logic       rx_parity_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam logic [3:0] MID_SAMPLE  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state;
  logic [3:0]           sample_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 tick;
  logic                 restart;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign restart = (state == ST_IDLE) && !rx_s;
  assign rx_busy = (state != ST_IDLE);

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign rx_parity_err = 1'b0;
`endif

  // NOTE: sequential state uses <= so every branch reads pre-edge values;
  // later assignments in the same block take priority over earlier defaults.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      sample_cnt   <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad       <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_frame_err <= 1'b0;
      if (rx_ack && rx_valid) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state      <= ST_START;
            sample_cnt <= '0;
          end
        end

        ST_START: begin
          if (tick) begin
            if (sample_cnt == MID_SAMPLE) begin
              if (rx_s) begin
                state <= ST_IDLE;
              end else begin
                state      <= ST_DATA;
                sample_cnt <= '0;
                bit_cnt    <= '0;
              end
            end else begin
              sample_cnt <= sample_cnt + 4'd1;
            end
          end
        end

        // Counter wraps 15 -> 0, so each 16th tick lands mid-bit.
        ST_DATA: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
            if (sample_cnt == LAST_SAMPLE) begin
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
            if (sample_cnt == LAST_SAMPLE) begin
              par_bad <= (rx_s != parity_bit(shift_reg, PARITY_ODD != 0));
              state   <= ST_STOP;
            end
          end
        end
`endif

        ST_STOP: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
            if (sample_cnt == LAST_SAMPLE) begin
              if (rx_s) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ack) begin
                  rx_overrun <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                rx_parity_err <= par_bad;
`endif
                state <= ST_IDLE;
              end else begin
                rx_frame_err <= 1'b1;
                state        <= ST_BREAK;
              end
            end
          end
        end

        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed + randomized bench for uart_rx_oversample at CLK_DIV=4 (64-cycle bit).
// Expected results come from a frame-level model of receiver behaviour.
module tb_uart_rx_oversample;

  localparam int CLK_DIV    = 4;
  localparam int PARITY_ODD = 0;
  localparam int OS         = 16;
  localparam int BIT_CYC    = OS * CLK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Two synchronizer stages + one detect cycle, then mid-stop is half a bit
  // past the start bit, data bits and optional parity bit.
  localparam int LAT = 3 + (OS / 2 + OS * (1 + 8 + PAR_BITS)) * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_overrun;
  logic       rx_busy;

  uart_rx_oversample #(.CLK_DIV(CLK_DIV), .PARITY_ODD(PARITY_ODD)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ack       (rx_ack),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Cycle counter and output monitor (observation only).
  int   cyc = 0;
  int   valid_rises = 0;
  int   last_rise_cyc = 0;
  int   fe_cycles = 0;
  int   fe_rises = 0;
  logic prev_valid = 1'b0;
  logic prev_fe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      valid_rises   <= valid_rises + 1;
      last_rise_cyc <= cyc;
    end
    if (rx_frame_err) fe_cycles <= fe_cycles + 1;
    if (rx_frame_err && !prev_fe) fe_rises <= fe_rises + 1;
    prev_valid <= rx_valid;
    prev_fe    <= rx_frame_err;
  end

  // Frame-level reference model.
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       m_perr  = 1'b0;
  int         start_cyc = 0;

  function automatic logic good_par(input logic [7:0] d);
    return logic'(($countones(d) + PARITY_ODD) % 2);
  endfunction

  task automatic model_frame(input logic [7:0] d, input logic stop_bit,
                             input logic par_bit, input logic ack_same);
    if (stop_bit) begin
      if (m_valid && ack_same) m_ovr = 1'b0;
      else if (m_valid)        m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = d;
`ifdef UART_RX_PARITY_EN
      m_perr = logic'((($countones(d) + int'(par_bit)) % 2) != PARITY_ODD);
`else
      m_perr = par_bit & 1'b0;
`endif
    end
  endtask

  task automatic model_ack();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".data"},     32'(rx_data),       32'(m_data));
    check({tag, ".valid"},    32'(rx_valid),      32'(m_valid));
    check({tag, ".overrun"},  32'(rx_overrun),    32'(m_ovr));
    check({tag, ".par_err"},  32'(rx_parity_err), 32'(m_perr));
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CYC) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    #1 rx_ack = 1'b1;
    @(posedge clk);
    #1 rx_ack = 1'b0;
    model_ack();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       p;
    logic [7:0] d5a;
    int         base_rise;
    int         base_fe;
    int         base_fe_rise;
    int         wait_cnt;

    rx     = 1'b1;
    rx_ack = 1'b0;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.data",     32'(rx_data),       32'h0);
    check("rst.valid",    32'(rx_valid),      32'h0);
    check("rst.frame",    32'(rx_frame_err),  32'h0);
    check("rst.parity",   32'(rx_parity_err), 32'h0);
    check("rst.overrun",  32'(rx_overrun),    32'h0);
    check("rst.busy",     32'(rx_busy),       32'h0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Good frame 0xA5 with exact delivery latency and no framing error.
    base_fe = fe_cycles;
    send_frame(8'hA5, 1'b1, good_par(8'hA5));
    model_frame(8'hA5, 1'b1, good_par(8'hA5), 1'b0);
    check_state("a5");
    check("a5.latency", 32'(last_rise_cyc - start_cyc), 32'(LAT));
    check("a5.no_frame_err", 32'(fe_cycles - base_fe), 32'h0);
    pulse_ack();
    check("a5.ack_valid", 32'(rx_valid), 32'(m_valid));

    // Acknowledge with nothing pending must be ignored.
    pulse_ack();
    check("idle_ack.valid", 32'(rx_valid), 32'(m_valid));

    // Randomized bytes, each acknowledged.
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
`ifdef UART_RX_PARITY_EN
      p = 1'($urandom_range(0, 1));
`else
      p = good_par(d);
`endif
      send_frame(d, 1'b1, p);
      model_frame(d, 1'b1, p, 1'b0);
      check_state("rand");
      pulse_ack();
      check("rand.ack_valid", 32'(rx_valid), 32'(m_valid));
    end

    // Short low glitch on an idle line: rejected at mid start bit.
    base_rise = valid_rises;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("glitch.busy_hi", 32'(rx_busy), 32'h1);
    rx = 1'b1;
    wait_cnt = 0;
    while (rx_busy && wait_cnt < 40) begin
      @(posedge clk);
      #1;
      wait_cnt++;
    end
    check("glitch.busy_lo", 32'(rx_busy), 32'h0);
    check("glitch.no_byte", 32'(valid_rises - base_rise), 32'h0);
    check("glitch.valid", 32'(rx_valid), 32'h0);

    // Bad stop bit, then line held low: one error pulse, stays in break.
    base_rise    = valid_rises;
    base_fe      = fe_cycles;
    base_fe_rise = fe_rises;
    send_frame(8'h3C, 1'b0, good_par(8'h3C));
    model_frame(8'h3C, 1'b0, good_par(8'h3C), 1'b0);
    repeat (200) @(posedge clk);
    #1;
    check("break.fe_cycles", 32'(fe_cycles - base_fe), 32'h1);
    check("break.fe_pulses", 32'(fe_rises - base_fe_rise), 32'h1);
    check("break.busy", 32'(rx_busy), 32'h1);
    check("break.no_byte", 32'(valid_rises - base_rise), 32'h0);
    check_state("break");
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("break.release_busy", 32'(rx_busy), 32'h0);

    // Two bytes without acknowledge -> overrun, then acknowledge clears.
    send_frame(8'h11, 1'b1, good_par(8'h11));
    model_frame(8'h11, 1'b1, good_par(8'h11), 1'b0);
    check_state("ovr1");
    send_frame(8'h22, 1'b1, good_par(8'h22));
    model_frame(8'h22, 1'b1, good_par(8'h22), 1'b0);
    check_state("ovr2");
    pulse_ack();
    check_state("ovr_ack");

    // Acknowledge landing on the stop-bit sample edge: no overrun.
    send_frame(8'h33, 1'b1, good_par(8'h33));
    model_frame(8'h33, 1'b1, good_par(8'h33), 1'b0);
    check_state("pre_same");
    fork
      send_frame(8'h44, 1'b1, good_par(8'h44));
      begin
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
      end
    join
    model_frame(8'h44, 1'b1, good_par(8'h44), 1'b1);
    check_state("same_ack");
    pulse_ack();
    check("same_ack.clear", 32'(rx_valid), 32'(m_valid));

    // Reset in the middle of data bit 3 of 0x5A, then a clean 0x81.
    base_rise = valid_rises;
    d5a = 8'h5A;
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d5a[i]);
    rx = d5a[3];
    repeat (BIT_CYC / 2) @(posedge clk);
    #1;
    check("rst_mid.busy_before", 32'(rx_busy), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_perr  = 1'b0;
    check_state("rst_mid");
    check("rst_mid.busy", 32'(rx_busy), 32'h0);
    rx = 1'b1;
    repeat (2 * BIT_CYC) @(posedge clk);
    #1;
    send_frame(8'h81, 1'b1, good_par(8'h81));
    model_frame(8'h81, 1'b1, good_par(8'h81), 1'b0);
    check_state("x81");
    check("x81.only_byte", 32'(valid_rises - base_rise), 32'h1);
    pulse_ack();

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity expects a 1.
    send_frame(8'h07, 1'b1, 1'b0);
    model_frame(8'h07, 1'b1, 1'b0, 1'b0);
    check_state("par_bad");
    check("par_bad.err", 32'(rx_parity_err), 32'h1);
    pulse_ack();
    send_frame(8'h07, 1'b1, 1'b1);
    model_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check_state("par_good");
    check("par_good.err", 32'(rx_parity_err), 32'h0);
    pulse_ack();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 SHALL have parameter CLK_DIV, default 27, meaning clk cycles per oversample tick (bit period = 16*CLK_DIV cycles); legal range 2..1023.
REQ-002 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity; used only under UART_RX_PARITY_EN.
REQ-003 SHALL have port clk  input  1  the single system clock, rising-edge.
REQ-004 SHALL have port reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data  output  8  last received byte.
REQ-007 SHALL have port rx_valid  output  1  byte available; held until acknowledged.
REQ-008 SHALL have port rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-009 SHALL have port rx_frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 SHALL have port rx_parity_err  output  1  qualifies rx_valid byte; constant 0 without UART_RX_PARITY_EN.
REQ-011 SHALL have port rx_overrun  output  1  sticky: byte completed while rx_valid high.
REQ-012 SHALL have port rx_busy  output  1  high in any state except IDLE.

Function
REQ-013 SHALL pass rx through two flops (reset value 1) to form rx_s; all logic uses rx_s only.
REQ-014 SHALL generate a tick every CLK_DIV cycles; the tick divider restarts at 0 on the cycle IDLE detects rx_s==0.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP, BREAK; a 4-bit sample counter counts ticks per bit.
REQ-016 IDLE: rx_s==0 -> START, sample counter cleared.
REQ-017 START: on 8th tick (mid-bit), rx_s==1 -> IDLE (glitch rejected, no output); rx_s==0 -> DATA, counter cleared.
REQ-018 DATA: every 16th tick samples rx_s, LSB first, into shift register; after bit 7 -> PARITY if compiled in, else STOP.
REQ-019 STOP: on 16th tick samples rx_s; 1 -> rx_data loaded, rx_valid set next cycle, -> IDLE; 0 -> rx_frame_err pulsed, rx_valid unchanged, rx_data unchanged, -> BREAK.
REQ-020 BREAK: waits for rx_s==1, then -> IDLE.
REQ-021 Latency: rx_valid rises exactly 1 cycle after the stop-bit mid-sample tick.
REQ-022 rx_ack while rx_valid high clears rx_valid and rx_overrun next cycle; rx_ack while rx_valid low is ignored.
REQ-023 Good stop while rx_valid high (and no same-cycle rx_ack): rx_data overwritten, rx_valid stays 1, rx_overrun set; with same-cycle rx_ack: rx_data overwritten, rx_valid stays 1, rx_overrun not set.

Reset
REQ-024 reset SHALL, at any point including mid-byte, force IDLE, rx_data=0x00, rx_valid=0, rx_frame_err=0, rx_parity_err=0, rx_overrun=0, rx_busy=0, tick and sample counters 0.

Configuration
REQ-025 Macro UART_RX_PARITY_EN SHALL, when defined, add state PARITY: one bit sampled on 16th tick, checked against XOR of data (inverted if PARITY_ODD=1), result registered into rx_parity_err alongside rx_valid; byte delivered regardless.
REQ-026 Without UART_RX_PARITY_EN, DATA -> STOP directly, frame is 10 bits, rx_parity_err tied 0.

Structure
REQ-027 Package uart_pkg SHALL hold the state enum, OVERSAMPLE=16 and DATA_BITS=8 constants.
REQ-028 Tick generation SHALL be a sub-module uart_baud_tick (ports clk, reset, restart, tick), reusable by the transmitter.

Verification (CLK_DIV=4, bit = 64 cycles)
REQ-029 Frame 0xA5, good stop -> rx_data=0xA5, rx_valid=1, rx_frame_err never pulses.
REQ-030 rx low 20 cycles then high -> returns IDLE, rx_valid stays 0, rx_busy falls within 40 cycles.
REQ-031 Frame 0x3C with stop=0 -> one-cycle rx_frame_err, rx_valid=0; line held low 200 cycles -> stays BREAK, no new byte.
REQ-032 0x11 then 0x22 without rx_ack -> rx_data=0x22, rx_overrun=1; rx_ack -> rx_valid=0, rx_overrun=0.
REQ-033 reset asserted at data bit 3 of 0x5A, then frame 0x81 -> only 0x81 delivered.
REQ-034 With UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 0 -> rx_valid=1, rx_parity_err=1; parity bit 1 -> rx_parity_err=0.
